// File: rtl/milStd1553_pkg.sv
// ---------------------------------------------------------------------------
// milStd1553 -- shared MIL-STD-1553 word types plus the push-arbiter
// definitions (FSM state encoding and default watchdog length).
//
// Contents:
//   WordType            kind of 1553 word carried on a push channel
//   MilData             {dataType, dataWord} as presented on IPushMil.data
//   ArbState            mil_push_arbiter FSM states
//   ARB_TIMEOUT_CYCLES  default WAIT-state watchdog length
// ---------------------------------------------------------------------------
package milStd1553;

    typedef enum logic [1:0] {
        WCOMMAND = 2'd0,
        WSTATUS  = 2'd1,
        WDATA    = 2'd2
    } WordType;

    typedef struct packed {
        WordType     dataType;
        logic [15:0] dataWord;
    } MilData;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } ArbState;

    localparam int ARB_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/mil_push_if.sv
// ---------------------------------------------------------------------------
// IPushMil -- one-word push handshake.
//   request : one-cycle pulse from master, data valid and held until done
//   data    : MilData word
//   done    : one-cycle pulse from slave when the word has been consumed
// ---------------------------------------------------------------------------
interface IPushMil;
    import milStd1553::*;

    logic   request;
    MilData data;
    logic   done;

    modport master (output request, output data, input done);
    modport slave  (input request, input data, output done);

endinterface

// File: rtl/milWatchdog.sv
// ---------------------------------------------------------------------------
// milWatchdog -- counts enabled cycles from 0 and flags the cycle in which
// the count reaches TIMEOUT_CYCLES-1.
//   clk     : clock
//   rst     : asynchronous active-low reset
//   clear   : synchronous restart of the count at 0
//   enable  : count this cycle
//   expired : high while enabled and the count equals TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module milWatchdog
    import milStd1553::*;
#(
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);
    assign expired   = enable && w_at_last;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values; the async reset puts them in a known state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !w_at_last) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mil_push_arbiter.sv
// ---------------------------------------------------------------------------
// mil_push_arbiter -- two push requesters sharing one MIL word sink.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset; aborts any transfer silently
//   chA, chB : requester channels (slave side)
//   out      : shared sink (master side)
//   grant    : one-hot owner of out, bit0 = A, bit1 = B
//   timeout  : one-cycle pulse (in REPORT) when the watchdog aborted a transfer
//   errCount : saturating count of timeouts plus repeated-request violations
// ---------------------------------------------------------------------------
module mil_push_arbiter
    import milStd1553::*;
#(
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    IPushMil.slave     chA,
    IPushMil.slave     chB,
    IPushMil.master    out,
    output logic [1:0] grant,
    output logic       timeout,
    output logic [7:0] errCount
);

    ArbState     r_state;
    ArbState     w_next;
    logic        r_pend_a;
    logic        r_pend_b;
    logic [1:0]  r_grant;
    MilData      r_data;
    logic        r_prio_b;      // 1: B wins the next tie
    logic        r_timeout;
    logic [7:0]  r_err;

    logic        w_pend_a;
    logic        w_pend_b;
    logic [1:0]  w_pick;
    logic        w_done_a;
    logic        w_done_b;
    logic        w_expired;
    logic        w_timeout_evt;
    logic        w_viol_a;
    logic        w_viol_b;
    logic [1:0]  w_inc;
    logic [8:0]  w_sum;

    milWatchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (r_state != WAIT),
        .enable  (r_state == WAIT),
        .expired (w_expired)
    );

    // Requests arriving this cycle are bypassed into arbitration so a request
    // seen at edge N in IDLE is issued in cycle N+1.
    assign w_pend_a = r_pend_a | chA.request;
    assign w_pend_b = r_pend_b | chB.request;

    assign w_done_a = (r_state == REPORT) && r_grant[0];
    assign w_done_b = (r_state == REPORT) && r_grant[1];

    // out.done wins over a simultaneous expiry; done outside WAIT is ignored.
    assign w_timeout_evt = (r_state == WAIT) && !out.done && w_expired;

    // A request coinciding with the channel's own done is a fresh request.
    assign w_viol_a = chA.request && r_pend_a && !w_done_a;
    assign w_viol_b = chB.request && r_pend_b && !w_done_b;

    assign w_inc = 2'(w_viol_a) + 2'(w_viol_b) + 2'(w_timeout_evt);
    assign w_sum = {1'b0, r_err} + {7'd0, w_inc};

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        w_pick = 2'b00;
        unique case (r_state)
            IDLE: begin
                if (w_pend_a || w_pend_b) begin
                    w_next = ISSUE;
                    if (w_pend_a && w_pend_b) begin
                        w_pick = r_prio_b ? 2'b10 : 2'b01;
                    end else begin
                        w_pick = w_pend_a ? 2'b01 : 2'b10;
                    end
                end
            end
            ISSUE:  w_next = WAIT;
            WAIT:   if (out.done || w_expired) w_next = REPORT;
            REPORT: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_pend_a  <= 1'b0;
            r_pend_b  <= 1'b0;
            r_grant   <= 2'b00;
            r_data    <= '0;
            r_prio_b  <= 1'b0;
            r_timeout <= 1'b0;
            r_err     <= 8'd0;
        end else begin
            r_state   <= w_next;
            r_pend_a  <= chA.request | (r_pend_a & ~w_done_a);
            r_pend_b  <= chB.request | (r_pend_b & ~w_done_b);
            r_timeout <= w_timeout_evt;
            r_err     <= w_sum[8] ? 8'hFF : w_sum[7:0];
            if (r_state == IDLE && w_next == ISSUE) begin
                r_grant  <= w_pick;
                r_data   <= w_pick[1] ? chB.data : chA.data;
                r_prio_b <= w_pick[0];
            end else if (r_state == REPORT) begin
                r_grant <= 2'b00;
            end
        end
    end

    assign out.request = (r_state == ISSUE);
    assign out.data    = r_data;
    assign chA.done    = w_done_a;
    assign chB.done    = w_done_b;
    assign grant       = r_grant;
    assign timeout     = r_timeout;
    assign errCount    = r_err;

endmodule

// File: tb/tb_mil_push_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mil_push_arbiter -- directed bench for mil_push_arbiter (TIMEOUT_CYCLES
// = 16). Inputs change and outputs are sampled on the falling clock edge.
// Words expected on the sink are queued when a requester is driven and
// compared whenever out.request is seen.
// ---------------------------------------------------------------------------
module tb_mil_push_arbiter;
    import milStd1553::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;
    logic       timeout;
    logic [7:0] err_count;

    int checks    = 0;
    int failures  = 0;
    int req_count = 0;
    int n0;
    bit sb_en     = 1'b1;
    logic early;

    MilData exp_q[$];
    MilData w1, w2, w3, w4, w5, w6, w7;

    IPushMil chA_if ();
    IPushMil chB_if ();
    IPushMil out_if ();

    mil_push_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .chA      (chA_if),
        .chB      (chB_if),
        .out      (out_if),
        .grant    (grant),
        .timeout  (timeout),
        .errCount (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Scoreboard: every issued word must match the oldest queued word.
    always @(negedge clk) begin
        MilData want;
        if (sb_en && out_if.request === 1'b1) begin
            req_count++;
            want = '1;
            if (exp_q.size() != 0) want = exp_q.pop_front();
            check("sb_data", 32'(out_if.data), 32'(want));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL tb_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        w1 = '{WDATA,    16'hA5A5};
        w2 = '{WCOMMAND, 16'h2222};
        w3 = '{WSTATUS,  16'h3333};
        w4 = '{WDATA,    16'h4444};
        w5 = '{WCOMMAND, 16'h5555};
        w6 = '{WDATA,    16'h6666};
        w7 = '{WSTATUS,  16'h7777};
        rst = 1'b0;
        chA_if.request = 1'b0; chA_if.data = '0;
        chB_if.request = 1'b0; chB_if.data = '0;
        out_if.done = 1'b0;
        step(); step();

        // Reset state
        check("rst_grant",   32'(grant), 32'(2'b00));
        check("rst_req",     32'(out_if.request), 32'd0);
        check("rst_data",    32'(out_if.data), 32'd0);
        check("rst_done_a",  32'(chA_if.done), 32'd0);
        check("rst_done_b",  32'(chB_if.done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_err",     32'(err_count), 32'd0);
        rst = 1'b1;
        step();

        // Single A request, sink done 3 cycles after out.request
        chA_if.data = w1; chA_if.request = 1'b1; exp_q.push_back(w1);
        step(); chA_if.request = 1'b0;
        check("t1_req",   32'(out_if.request), 32'd1);
        check("t1_grant", 32'(grant), 32'(2'b01));
        step();
        check("t1_req_once", 32'(out_if.request), 32'd0);
        step();
        step(); out_if.done = 1'b1;
        step(); out_if.done = 1'b0;
        check("t1_done_a",  32'(chA_if.done), 32'd1);
        check("t1_done_b",  32'(chB_if.done), 32'd0);
        check("t1_data",    32'(out_if.data), 32'(w1));
        check("t1_grant_r", 32'(grant), 32'(2'b01));
        step();
        check("t1_done_end", 32'(chA_if.done), 32'd0);
        check("t1_grant_0",  32'(grant), 32'(2'b00));
        check("t1_err",      32'(err_count), 32'd0);

        // A and B together after reset: A first, then B
        do_reset();
        n0 = req_count;
        chA_if.data = w1; chB_if.data = w2;
        chA_if.request = 1'b1; chB_if.request = 1'b1;
        exp_q.push_back(w1); exp_q.push_back(w2);
        step(); chA_if.request = 1'b0; chB_if.request = 1'b0;
        check("t2_grant_a", 32'(grant), 32'(2'b01));
        check("t2_req_a",   32'(out_if.request), 32'd1);
        step(); out_if.done = 1'b1;
        step(); out_if.done = 1'b0;
        check("t2_done_a", 32'(chA_if.done), 32'd1);
        step();
        check("t2_grant_idle", 32'(grant), 32'(2'b00));
        check("t2_req_idle",   32'(out_if.request), 32'd0);
        step();
        check("t2_grant_b", 32'(grant), 32'(2'b10));
        check("t2_req_b",   32'(out_if.request), 32'd1);
        step(); out_if.done = 1'b1;
        step(); out_if.done = 1'b0;
        check("t2_done_b",  32'(chB_if.done), 32'd1);
        check("t2_done_a0", 32'(chA_if.done), 32'd0);
        repeat (3) step();
        check("t2_grant_end", 32'(grant), 32'(2'b00));
        check("t2_nreq",      32'(req_count - n0), 32'd2);

        // Sink never answers: watchdog
        do_reset();
        chA_if.data = w3; chA_if.request = 1'b1; exp_q.push_back(w3);
        step(); chA_if.request = 1'b0;
        check("t3_req", 32'(out_if.request), 32'd1);
        early = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            early = early | timeout | chA_if.done;
        end
        check("t3_no_early", 32'(early), 32'd0);
        check("t3_grant_w",  32'(grant), 32'(2'b01));
        step(); out_if.done = 1'b1;
        check("t3_timeout", 32'(timeout), 32'd1);
        check("t3_done_a",  32'(chA_if.done), 32'd1);
        check("t3_err",     32'(err_count), 32'd1);
        step();
        check("t3_tmo_pulse", 32'(timeout), 32'd0);
        step(); out_if.done = 1'b0;
        check("t3_stray_req",   32'(out_if.request), 32'd0);
        check("t3_stray_grant", 32'(grant), 32'(2'b00));
        check("t3_stray_done",  32'(chA_if.done), 32'd0);
        check("t3_stray_err",   32'(err_count), 32'd1);

        // B requests again while pending
        do_reset();
        n0 = req_count;
        chB_if.data = w4; chB_if.request = 1'b1; exp_q.push_back(w4);
        step(); chB_if.request = 1'b0;
        check("t4_grant", 32'(grant), 32'(2'b10));
        step(); chB_if.data = w5; chB_if.request = 1'b1;
        step(); chB_if.request = 1'b0; out_if.done = 1'b1;
        check("t4_err", 32'(err_count), 32'd1);
        step(); out_if.done = 1'b0;
        check("t4_done_b", 32'(chB_if.done), 32'd1);
        check("t4_data",   32'(out_if.data), 32'(w4));
        repeat (4) step();
        check("t4_nreq",    32'(req_count - n0), 32'd1);
        check("t4_err_end", 32'(err_count), 32'd1);
        check("t4_data_end", 32'(out_if.data), 32'(w4));

        // Reset during WAIT
        chA_if.data = w6; chA_if.request = 1'b1; exp_q.push_back(w6);
        step(); chA_if.request = 1'b0;
        step();
        check("t5_grant_w", 32'(grant), 32'(2'b01));
        #2 rst = 1'b0;
        #1;
        check("t5_grant", 32'(grant), 32'(2'b00));
        check("t5_req",   32'(out_if.request), 32'd0);
        check("t5_data",  32'(out_if.data), 32'd0);
        check("t5_done",  32'(chA_if.done), 32'd0);
        check("t5_tmo",   32'(timeout), 32'd0);
        check("t5_err",   32'(err_count), 32'd0);
        step(); step();
        check("t5_no_done", 32'(chA_if.done), 32'd0);
        rst = 1'b1;
        chA_if.data = w7; chA_if.request = 1'b1; exp_q.push_back(w7);
        step(); chA_if.request = 1'b0;
        check("t5_req_after", 32'(out_if.request), 32'd1);
        step(); out_if.done = 1'b1;
        step(); out_if.done = 1'b0;
        check("t5_done_after", 32'(chA_if.done), 32'd1);
        step();

        // Forced violations saturate errCount
        do_reset();
        sb_en = 1'b0;
        for (int k = 0; k < 200; k++) begin
            chA_if.request = 1'b1; chB_if.request = 1'b1;
            step();
        end
        check("t6_sat", 32'(err_count), 32'd255);
        for (int k = 0; k < 20; k++) step();
        chA_if.request = 1'b0; chB_if.request = 1'b0;
        step();
        check("t6_hold", 32'(err_count), 32'd255);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
